// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared widths and operand bundle for the arbitrated arithmetic pipe
package arith_pkg;

  localparam int OPW  = 8;
  localparam int SUMW = 9;
  localparam int RESW = 17;

  typedef struct packed {
    logic [OPW-1:0] a;
    logic [OPW-1:0] b;
    logic [OPW-1:0] c;
    logic [OPW-1:0] d;
  } op_t;

endpackage

// File: rtl/arith_pipe3.sv
// rtl/arith_pipe3.sv - ID-tagged 3-stage datapath computing (a + b) * c + d, never stalls
module arith_pipe3
  import arith_pkg::*;
#(
  parameter int IDW = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_v,
  input  logic [IDW-1:0]  in_id,
  input  logic [OPW-1:0]  a,
  input  logic [OPW-1:0]  b,
  input  logic [OPW-1:0]  c,
  input  logic [OPW-1:0]  d,
  output logic            out_v,
  output logic [IDW-1:0]  out_id,
  output logic [RESW-1:0] y,
  output logic            busy
);

  logic            s1_v;
  logic [IDW-1:0]  s1_id;
  logic [SUMW-1:0] s1_sum;
  logic [OPW-1:0]  s1_c;
  logic [OPW-1:0]  s1_d;

  logic            s2_v;
  logic [IDW-1:0]  s2_id;
  logic [RESW-1:0] s2_prod;
  logic [OPW-1:0]  s2_d;

  // Data registers carry no reset; only the valid bits and visible result are cleared.
  always_ff @(posedge clk) begin
    s1_sum  <= SUMW'(a) + SUMW'(b);
    s1_c    <= c;
    s1_d    <= d;
    s1_id   <= in_id;
    s2_prod <= RESW'(s1_sum) * RESW'(s1_c);
    s2_d    <= s1_d;
    s2_id   <= s1_id;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v   <= 1'b0;
      s2_v   <= 1'b0;
      out_v  <= 1'b0;
      out_id <= '0;
      y      <= '0;
    end else begin
      s1_v  <= in_v;
      s2_v  <= s1_v;
      out_v <= s2_v;
      if (s2_v) begin
        out_id <= s2_id;
        y      <= s2_prod + RESW'(s2_d);
      end
    end
  end

  assign busy = s1_v | s2_v | out_v;

endmodule

// File: rtl/arith_pipe_arbiter.sv
// rtl/arith_pipe_arbiter.sv - round-robin arbiter sharing one arithmetic pipe among requesters
module arith_pipe_arbiter
  import arith_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*OPW-1:0] req_a,
  input  logic [NUM_REQ*OPW-1:0] req_b,
  input  logic [NUM_REQ*OPW-1:0] req_c,
  input  logic [NUM_REQ*OPW-1:0] req_d,
  input  logic                   hold,
  output logic                   res_valid,
  output logic [IDW-1:0]         res_id,
  output logic [RESW-1:0]        res_y,
  output logic                   busy,
  output logic [15:0]            ops_count
);

  localparam int NSLOT = 2 ** IDW;

  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   grant_id;
  logic [IDW-1:0]   idx;
  logic             found;
  logic             xfer;
  logic [NSLOT-1:0] valid_ext;
  logic [NSLOT-1:0] ready_ext;
  op_t              sel_op;

  assign valid_ext = NSLOT'(req_valid);

  // Search ascending from rr_ptr with wrap at NUM_REQ; first valid requester wins.
  always_comb begin
    found     = 1'b0;
    grant_id  = '0;
    idx       = '0;
    ready_ext = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (int'(rr_ptr) + k >= NUM_REQ) idx = IDW'(int'(rr_ptr) + k - NUM_REQ);
      else                             idx = IDW'(int'(rr_ptr) + k);
      if (!found && valid_ext[idx]) begin
        found    = 1'b1;
        grant_id = idx;
      end
    end
    if (found && !hold && !rst) ready_ext[grant_id] = 1'b1;
  end

  assign req_ready = ready_ext[NUM_REQ-1:0];
  assign xfer      = |req_ready;

  always_comb begin
    sel_op = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDW'(i) == grant_id) begin
        sel_op.a = req_a[i*OPW +: OPW];
        sel_op.b = req_b[i*OPW +: OPW];
        sel_op.c = req_c[i*OPW +: OPW];
        sel_op.d = req_d[i*OPW +: OPW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (xfer) begin
      rr_ptr <= (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + IDW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ops_count <= '0;
    end else if (res_valid && ops_count != 16'hFFFF) begin
      ops_count <= ops_count + 16'd1;
    end
  end

  arith_pipe3 #(
    .IDW (IDW)
  ) u_pipe (
    .clk    (clk),
    .rst    (rst),
    .in_v   (xfer),
    .in_id  (grant_id),
    .a      (sel_op.a),
    .b      (sel_op.b),
    .c      (sel_op.c),
    .d      (sel_op.d),
    .out_v  (res_valid),
    .out_id (res_id),
    .y      (res_y),
    .busy   (busy)
  );

endmodule

// File: tb/tb_arith_pipe_arbiter.sv
// tb/tb_arith_pipe_arbiter.sv - directed self-checking bench for arith_pipe_arbiter
module tb_arith_pipe_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [31:0] req_c;
  logic [31:0] req_d;
  logic        hold;
  logic        res_valid;
  logic [1:0]  res_id;
  logic [16:0] res_y;
  logic        busy;
  logic [15:0] ops_count;

  int n_cmp = 0;
  int n_bad = 0;

  int y_tab [4] = '{4, 7, 10, 13};

  always #5 clk = ~clk;

  arith_pipe_arbiter #(
    .NUM_REQ (4),
    .IDW     (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_c     (req_c),
    .req_d     (req_d),
    .hold      (hold),
    .res_valid (res_valid),
    .res_id    (res_id),
    .res_y     (res_y),
    .busy      (busy),
    .ops_count (ops_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_ops(input int i, input int a, input int b, input int c, input int d);
    req_a[8*i +: 8] = 8'(a);
    req_b[8*i +: 8] = 8'(b);
    req_c[8*i +: 8] = 8'(c);
    req_d[8*i +: 8] = 8'(d);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = 4'b0000;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    hold      = 1'b0;
    req_valid = 4'b1111;
    req_a = '0; req_b = '0; req_c = '0; req_d = '0;

    // reset state
    tick();
    settle();
    check("rst_ready", 32'(req_ready), 32'd0);
    tick();
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_ops", 32'(ops_count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    req_valid = 4'b0000;

    // single request: (2+3)*4+1 = 21
    set_ops(0, 2, 3, 4, 1);
    req_valid = 4'b0001;
    settle();
    check("single_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 4'b0000;
    check("single_lat1", 32'(res_valid), 32'd0);
    tick();
    check("single_lat2", 32'(res_valid), 32'd0);
    tick();
    check("single_valid", 32'(res_valid), 32'd1);
    check("single_id", 32'(res_id), 32'd0);
    check("single_y", 32'(res_y), 32'd21);
    check("single_busy_hi", 32'(busy), 32'd1);
    tick();
    check("single_valid_lo", 32'(res_valid), 32'd0);
    check("single_busy_lo", 32'(busy), 32'd0);
    check("single_ops", 32'(ops_count), 32'd1);

    // full contention from rr_ptr = 0
    do_reset();
    for (int i = 0; i < 4; i++) set_ops(i, i + 1, 1, 2, i);
    for (int t = 0; t < 12; t++) begin
      req_valid = (t < 8) ? 4'b1111 : 4'b0000;
      settle();
      if (t < 8) check($sformatf("cont_grant%0d", t), 32'(req_ready), 32'(4'b0001 << (t % 4)));
      tick();
      if (t >= 2 && t < 10) begin
        check($sformatf("cont_valid%0d", t), 32'(res_valid), 32'd1);
        check($sformatf("cont_id%0d", t), 32'(res_id), 32'((t - 2) % 4));
        check($sformatf("cont_y%0d", t), 32'(res_y), 32'(y_tab[(t - 2) % 4]));
      end else begin
        check($sformatf("cont_idle%0d", t), 32'(res_valid), 32'd0);
      end
    end
    check("cont_ops", 32'(ops_count), 32'd8);

    // max operands on requester 0, rr_ptr = 0
    set_ops(0, 255, 255, 255, 255);
    req_valid = 4'b0001;
    settle();
    check("max_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 4'b0000;
    tick();
    tick();
    check("max_valid", 32'(res_valid), 32'd1);
    check("max_y", 32'(res_y), 32'd130305);

    // hold with one operation in flight; rr_ptr = 1, requester 1 operands (2,1,2,1)
    req_valid = 4'b1111;
    settle();
    check("hold_pre_grant", 32'(req_ready), 32'b0010);
    tick();
    hold = 1'b1;
    for (int h = 0; h < 5; h++) begin
      settle();
      check($sformatf("hold_ready%0d", h), 32'(req_ready), 32'd0);
      tick();
      if (h == 1) begin
        check("hold_drain_valid", 32'(res_valid), 32'd1);
        check("hold_drain_id", 32'(res_id), 32'd1);
        check("hold_drain_y", 32'(res_y), 32'd7);
      end
      if (h == 4) check("hold_busy", 32'(busy), 32'd0);
    end
    hold = 1'b0;
    settle();
    check("hold_resume", 32'(req_ready), 32'b0100);
    tick();
    req_valid = 4'b0000;
    tick();
    tick();
    tick();

    // reset mid-operation; rr_ptr = 3
    req_valid = 4'b1111;
    settle();
    check("mid_grant3", 32'(req_ready), 32'b1000);
    tick();
    settle();
    check("mid_grant0", 32'(req_ready), 32'b0001);
    tick();
    rst = 1'b1;
    req_valid = 4'b0000;
    tick();
    check("mid_rst_valid", 32'(res_valid), 32'd0);
    rst = 1'b0;
    for (int r = 0; r < 3; r++) begin
      tick();
      check($sformatf("mid_no_res%0d", r), 32'(res_valid), 32'd0);
    end
    check("mid_ops", 32'(ops_count), 32'd0);
    check("mid_busy", 32'(busy), 32'd0);
    req_valid = 4'b1111;
    settle();
    check("mid_ptr0", 32'(req_ready), 32'b0001);

    // sparse requesters 1 and 3 from rr_ptr = 0
    req_valid = 4'b1010;
    settle();
    check("sparse_g1", 32'(req_ready), 32'b0010);
    tick();
    check("sparse_g3", 32'(req_ready), 32'b1000);
    tick();
    check("sparse_g1b", 32'(req_ready), 32'b0010);
    tick();
    req_valid = 4'b0000;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/arith_pipe_arbiter.md
Name: arith_pipe_arbiter

Overview:
- Shares one 3-stage pipelined arithmetic unit, Y = (A + B) * C + D, between NUM_REQ requesters.
- A round-robin arbiter grants at most one requester per cycle through a valid/ready handshake.
- Each granted operation carries its requester ID through the pipeline, and the result comes back tagged with that ID.
- The block sits between the requesting client blocks and the arithmetic datapath, and replaces direct per-client instances of the unit.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- IDW, 2, requester ID width; must satisfy 2^IDW >= NUM_REQ.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester operation request
- req_ready  out  NUM_REQ  per-requester grant; at most one bit high per cycle
- req_a  in  NUM_REQ*8  operand A, requester i at bits [8i+7:8i]
- req_b  in  NUM_REQ*8  operand B, same packing
- req_c  in  NUM_REQ*8  operand C, same packing
- req_d  in  NUM_REQ*8  operand D, same packing
- hold  in  1  when high, no new grants; in-flight operations drain
- res_valid  out  1  result strobe, one cycle per operation
- res_id  out  IDW  requester index of the result
- res_y  out  17  result (A+B)*C+D, full precision
- busy  out  1  any pipeline stage holds a valid operation
- ops_count  out  16  completed operations, saturating at 16'hFFFF

Behaviour:
- Reset (rst high at an edge):
  - Clears rr_ptr, all stage valid bits, res_valid, res_id, res_y and ops_count to 0.
  - Operations in flight are discarded with no res_valid.
  - While rst is high, req_ready = 0.
- Arbitration (combinational):
  - Search req_valid starting at index rr_ptr, ascending with wrap.
  - The first set bit i gets req_ready[i] = 1, only if hold = 0 and rst = 0.
  - req_ready depends on req_valid. Requesters must not make req_valid depend on req_ready.
- Handshake: a transfer occurs at an edge where req_valid[i] & req_ready[i].
  - On transfer: rr_ptr <= (i+1) mod NUM_REQ.
  - No transfer: rr_ptr holds.
  - A requester holds its valid and operands stable until it sees ready.
- Pipeline:
  - Never stalls; throughput is one operation per cycle.
  - Stage 1 (transfer edge k): s1_sum (9 bit) <= A+B; s1_c, s1_d, s1_id and s1_v captured.
  - Stage 2 (edge k+1): s2_prod (17 bit) <= s1_sum*s1_c; d, id and v forwarded.
  - Stage 3 (edge k+2): res_y <= s2_prod + s2_d; res_id and res_valid <= s2_v.
  - res_valid is therefore high for exactly the cycle after edge k+2, i.e. 3 edges after the transfer edge, counting the transfer edge.
  - Bubbles propagate as v = 0. res_y and res_id hold their last value when res_valid = 0.
- Widths:
  - No truncation anywhere.
  - Maximum result (255+255)*255+255 = 130305 fits in 17 bits.
- busy = s1_v | s2_v | res_valid.
- ops_count increments on each res_valid and saturates at 16'hFFFF.
- hold:
  - Takes effect combinationally: there is no grant in any cycle where hold is high.
  - Operations already accepted complete normally.
  - hold does not change rr_ptr.
- Simultaneous requests:
  - Exactly one grant per cycle.
  - With all requesters continuously valid, grants rotate 0,1,2,3,0,…

Decomposition:
- Shared package arith_pkg holds:
  - operand width OPW = 8
  - sum width SUMW = 9
  - result width RESW = 17
  - a packed struct op_t {a, b, c, d}
- One natural sub-module is arith_pipe3: a valid/ID-tagged 3-stage datapath with inputs in_v, in_id, a, b, c, d and outputs out_v, out_id, y.
- The top level contains the round-robin arbiter, the operand mux and ops_count.

Test Plan:
- Single request: reset 2 cycles; req_valid = 0001, operands 2, 3, 4, 1.
  - Required: req_ready[0] = 1, then res_valid = 1 with id 0 and y = 21, exactly 3 edges after the transfer.
  - Required: busy falls one cycle later.
- Full contention: all 4 requesters valid for 8 cycles, requester i operands (i+1, 1, 2, i), so y = 2(i+2)+i.
  - Required: grant order 0,1,2,3,0,1,2,3.
  - Required: back-to-back results with ids 0,1,2,3,… and y = 4, 7, 10, 13 repeating.
  - Required: ops_count = 8.
- Max operands: 255, 255, 255, 255.
  - Required: res_y = 130305 (17'h1FD01), no wrap.
- hold: 4 requesters valid with hold high for 5 cycles.
  - Required: req_ready = 0000 throughout.
  - Required: in-flight operations still produce res_valid; busy drops to 0.
  - After hold falls, the grant resumes at the saved rr_ptr.
- Reset mid-operation: transfer two operations, assert rst on the following edge.
  - Required: no res_valid ever appears for them.
  - Required: ops_count = 0, rr_ptr = 0, so the next contention is granted to requester 0 first.
- Sparse/skip: req_valid = 1010 with rr_ptr = 0.
  - Required: grant to 1, then 3, then 1; requesters 0 and 2 never granted.
